// File: rtl/crc_serial_param_framer.sv
// Bit-serial MSB-first Galois CRC framer: data passes through, CRC_W CRC bits follow with no gap.
// Optional receive-side check mode (chk_mode/crc_err) is enabled by defining CRC_CHECK_EN.
module crc_serial_param_framer #(
  parameter int               CRC_W = 7,
  parameter logic [CRC_W-1:0] POLY  = 7'h09,
  parameter logic [CRC_W-1:0] INIT  = '0,
  parameter int               CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_data,
  input  logic             in_last,
`ifdef CRC_CHECK_EN
  input  logic             chk_mode,
  output logic             crc_err,
`endif
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_data,
  output logic             out_is_crc,
  output logic             done,
  output logic [CRC_W-1:0] crc_val,
  output logic [CNT_W-1:0] frame_bits
);

  localparam int CW = $clog2(CRC_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC} state_t;

  state_t           r_state, w_state_nxt;
  logic [CRC_W-1:0] r_crc, w_crc_nxt, w_crc_shl, w_crc_upd;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_frame_bits, w_frame_bits_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_out_data, w_out_data_nxt;
  logic             r_out_is_crc, w_out_is_crc_nxt;
  logic             r_done_pend, w_done_pend_nxt;
  logic             r_done;
  logic             w_acc, w_fb, w_chk;

`ifdef CRC_CHECK_EN
  logic r_chk, r_err_pend, r_crc_err, w_chk_end;
  // chk_mode is only looked at on the first bit; later bits use the latched copy
  assign w_chk     = (r_state == S_IDLE) ? chk_mode : r_chk;
  assign w_chk_end = w_acc && in_last && w_chk;
`else
  assign w_chk = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_crc_nxt        = r_crc;
    w_cnt_nxt        = r_cnt;
    w_frame_bits_nxt = r_frame_bits;
    w_out_valid_nxt  = 1'b0;
    w_out_data_nxt   = 1'b0;
    w_out_is_crc_nxt = 1'b0;
    w_done_pend_nxt  = 1'b0;
    w_acc            = in_valid && (r_state != S_CRC);
    w_fb             = in_data ^ r_crc[CRC_W-1];
    w_crc_shl        = {r_crc[CRC_W-2:0], 1'b0};
    w_crc_upd        = w_crc_shl ^ (w_fb ? POLY : '0);
    case (r_state)
      S_IDLE, S_DATA: begin
        if (w_acc) begin
          w_crc_nxt       = w_crc_upd;
          w_out_valid_nxt = 1'b1;
          w_out_data_nxt  = in_data;
          if (r_state == S_IDLE) begin
            w_frame_bits_nxt = CNT_W'(1);
          end else if (r_frame_bits != '1) begin
            w_frame_bits_nxt = r_frame_bits + CNT_W'(1);
          end
          if (!in_last) begin
            w_state_nxt = S_DATA;
          end else if (w_chk) begin
            w_state_nxt     = S_IDLE;
            w_crc_nxt       = INIT;
            w_done_pend_nxt = 1'b1;
          end else begin
            w_state_nxt = S_CRC;
            w_cnt_nxt   = CW'(CRC_W);
          end
        end
      end
      S_CRC: begin
        w_crc_nxt        = w_crc_shl;
        w_cnt_nxt        = r_cnt - CW'(1);
        w_out_valid_nxt  = 1'b1;
        w_out_data_nxt   = r_crc[CRC_W-1];
        w_out_is_crc_nxt = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_state_nxt     = S_IDLE;
          w_crc_nxt       = INIT;
          w_done_pend_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // done lands one cycle after the frame's final output bit, hence the pending stage
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state      <= S_IDLE;
      r_crc        <= INIT;
      r_cnt        <= '0;
      r_frame_bits <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 1'b0;
      r_out_is_crc <= 1'b0;
      r_done_pend  <= 1'b0;
      r_done       <= 1'b0;
    end else if (clear) begin
      r_state      <= S_IDLE;
      r_crc        <= INIT;
      r_cnt        <= '0;
      r_frame_bits <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 1'b0;
      r_out_is_crc <= 1'b0;
      r_done_pend  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_crc        <= w_crc_nxt;
      r_cnt        <= w_cnt_nxt;
      r_frame_bits <= w_frame_bits_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_is_crc <= w_out_is_crc_nxt;
      r_done_pend  <= w_done_pend_nxt;
      r_done       <= r_done_pend;
    end
  end

`ifdef CRC_CHECK_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_chk      <= 1'b0;
      r_err_pend <= 1'b0;
      r_crc_err  <= 1'b0;
    end else if (clear) begin
      r_chk      <= 1'b0;
      r_err_pend <= 1'b0;
      r_crc_err  <= 1'b0;
    end else begin
      if (w_acc && (r_state == S_IDLE)) begin
        r_chk <= chk_mode;
      end
      if (w_done_pend_nxt) begin
        r_err_pend <= w_chk_end && (w_crc_upd != '0);
      end
      if (r_done_pend) begin
        r_crc_err <= r_err_pend;
      end
    end
  end

  assign crc_err = r_crc_err;
`endif

  assign in_ready   = (r_state != S_CRC);
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_is_crc = r_out_is_crc;
  assign done       = r_done;
  assign crc_val    = r_crc;
  assign frame_bits = r_frame_bits;

endmodule

// File: tb/tb_crc_serial_param_framer.sv
// Directed bench for crc_serial_param_framer: CRC7 default instance plus a CRC16-CCITT instance.
module tb_crc_serial_param_framer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RSTn, clear, in_valid, in_data, in_last;
  logic        in_ready, out_valid, out_data, out_is_crc, done;
  logic [6:0]  crc_val;
  logic [15:0] frame_bits;

  logic        clear16, v16, d16, l16, rdy16, ov16, od16, oc16, done16;
  logic [15:0] crc16, fb16;
`ifdef CRC_CHECK_EN
  logic        chk_mode, crc_err, chk16, err16;
`endif

  crc_serial_param_framer u_dut (
    .CLK(CLK), .RSTn(RSTn), .clear(clear), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
`ifdef CRC_CHECK_EN
    .chk_mode(chk_mode), .crc_err(crc_err),
`endif
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_is_crc(out_is_crc),
    .done(done), .crc_val(crc_val), .frame_bits(frame_bits)
  );

  crc_serial_param_framer #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .CNT_W(16)) u_d16 (
    .CLK(CLK), .RSTn(RSTn), .clear(clear16), .in_valid(v16), .in_data(d16), .in_last(l16),
`ifdef CRC_CHECK_EN
    .chk_mode(chk16), .crc_err(err16),
`endif
    .in_ready(rdy16), .out_valid(ov16), .out_data(od16), .out_is_crc(oc16),
    .done(done16), .crc_val(crc16), .frame_bits(fb16)
  );

  int n_tot = 0;
  int n_bad = 0;
  int stalls = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  int cyc = 0;
  int n_done16 = 0;
  bit q_dat[$];
  bit q_crc[$];
  int q_cyc[$];
  int d_cyc[$];

  always @(negedge CLK) begin
    if (RSTn && out_valid) begin
      q_dat.push_back(out_data);
      q_crc.push_back(out_is_crc);
      q_cyc.push_back(cyc);
    end
    if (RSTn && done) d_cyc.push_back(cyc);
    if (RSTn && done16) n_done16++;
    cyc = cyc + 1;
  end

  task automatic clr_mon();
    q_dat.delete();
    q_crc.delete();
    q_cyc.delete();
    d_cyc.delete();
  endtask

  logic [63:0] f_dat[4];
  logic [31:0] f_crc[4];
  int          f_nd[4];
  int          f_nc[4];
  int          f_last[4];
  int          nfr;

  task automatic analyse();
    nfr = 0;
    for (int k = 0; k < 4; k++) begin
      f_dat[k] = '0; f_crc[k] = '0; f_nd[k] = 0; f_nc[k] = 0; f_last[k] = 0;
    end
    for (int i = 0; i < q_dat.size(); i++) begin
      if (i > 0 && !q_crc[i] && q_crc[i-1]) nfr++;
      if (nfr < 4) begin
        if (q_crc[i]) begin
          f_crc[nfr] = {f_crc[nfr][30:0], q_dat[i]};
          f_nc[nfr]++;
        end else begin
          f_dat[nfr] = {f_dat[nfr][62:0], q_dat[i]};
          f_nd[nfr]++;
          f_last[nfr] = q_cyc[i];
        end
      end
    end
    if (q_dat.size() > 0) nfr++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Holds a bit on the input until the DUT takes it (bounded)
  task automatic drive_bit(input logic b, input logic last);
    bit ok;
    int g;
    in_valid = 1'b1; in_data = b; in_last = last;
    ok = 1'b0; g = 0;
    while (!ok && g < 50) begin
      @(negedge CLK);
      ok = in_ready;
      @(posedge CLK);
      #1;
      g++;
    end
    if (!ok) stalls++;
    in_valid = 1'b0; in_last = 1'b0; in_data = 1'b0;
  endtask

  // Gap cycles drive in_last without in_valid, which must be ignored
  task automatic send(input logic [63:0] d, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(d[i], i == 0);
      if (gaps && i > 0) begin
        in_last = 1'b1;
        tick(1);
        in_last = 1'b0;
      end
    end
  endtask

  int span;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [71:0] s9;
    RSTn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 1'b0; in_last = 1'b0;
    clear16 = 1'b0; v16 = 1'b0; d16 = 1'b0; l16 = 1'b0;
`ifdef CRC_CHECK_EN
    chk_mode = 1'b0; chk16 = 1'b0;
`endif
    tick(3);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_is_crc", 64'(out_is_crc), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_crc_val", 64'(crc_val), 64'd0);
    chk("rst_frame_bits", 64'(frame_bits), 64'd0);
    chk("rst_crc16_init", 64'(crc16), 64'hFFFF);
    RSTn = 1'b1;
    tick(2);

    // CMD0-style frame
    clr_mon();
    send(64'h40_0000_0000, 40, 1'b0);
    chk("f40_live_crc", 64'(crc_val), 64'h4A);
    tick(15);
    analyse();
    chk("f40_nfr", 64'(nfr), 64'd1);
    chk("f40_data", f_dat[0], 64'h40_0000_0000);
    chk("f40_nd", 64'(f_nd[0]), 64'd40);
    chk("f40_crc", 64'(f_crc[0]), 64'h4A);
    chk("f40_nc", 64'(f_nc[0]), 64'd7);
    chk("f40_ndone", 64'(d_cyc.size()), 64'd1);
    span = (d_cyc.size() > 0) ? d_cyc[0] - f_last[0] : -1;
    chk("f40_done_lat", 64'(span), 64'd8);
    chk("f40_frame_bits", 64'(frame_bits), 64'd40);
    chk("f40_crc_init", 64'(crc_val), 64'd0);

    // Back-to-back frames, continuous output stream
    clr_mon();
    send(64'h48_0000_01AA, 40, 1'b0);
    send(64'h51_0000_0000, 40, 1'b0);
    tick(15);
    analyse();
    chk("b2b_nfr", 64'(nfr), 64'd2);
    chk("b2b_dat0", f_dat[0], 64'h48_0000_01AA);
    chk("b2b_crc0", 64'(f_crc[0]), 64'h43);
    chk("b2b_dat1", f_dat[1], 64'h51_0000_0000);
    chk("b2b_crc1", 64'(f_crc[1]), 64'h2A);
    chk("b2b_nout", 64'(q_cyc.size()), 64'd94);
    span = (q_cyc.size() > 0) ? q_cyc[q_cyc.size()-1] - q_cyc[0] : -1;
    chk("b2b_no_gap", 64'(span), 64'd93);
    chk("b2b_ndone", 64'(d_cyc.size()), 64'd2);

    // in_valid toggling inside the frame
    clr_mon();
    send(64'h40_0000_0000, 40, 1'b1);
    chk("gap_live_crc", 64'(crc_val), 64'h4A);
    chk("gap_frame_bits", 64'(frame_bits), 64'd40);
    tick(15);
    analyse();
    chk("gap_data", f_dat[0], 64'h40_0000_0000);
    chk("gap_crc", 64'(f_crc[0]), 64'h4A);
    span = (q_cyc.size() >= 40) ? q_cyc[39] - q_cyc[0] : -1;
    chk("gap_span", 64'(span), 64'd78);
    chk("gap_ndone", 64'(d_cyc.size()), 64'd1);

    // Single-bit frame: 1 -> CRC equals POLY
    clr_mon();
    send(64'h1, 1, 1'b0);
    chk("one_frame_bits", 64'(frame_bits), 64'd1);
    tick(12);
    analyse();
    chk("one_data", f_dat[0], 64'h1);
    chk("one_nd", 64'(f_nd[0]), 64'd1);
    chk("one_crc", 64'(f_crc[0]), 64'h09);
    chk("one_ndone", 64'(d_cyc.size()), 64'd1);

    // clear on the 3rd CRC bit
    clr_mon();
    send(64'h40_0000_0000, 40, 1'b0);
    tick(3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clr_out_valid", 64'(out_valid), 64'd0);
    chk("clr_crc_val", 64'(crc_val), 64'd0);
    chk("clr_in_ready", 64'(in_ready), 64'd1);
    chk("clr_frame_bits", 64'(frame_bits), 64'd0);
    tick(12);
    analyse();
    chk("clr_ncrc", 64'(f_nc[0]), 64'd3);
    chk("clr_no_done", 64'(d_cyc.size()), 64'd0);

    // clear beats a same-cycle valid bit
    clr_mon();
    in_valid = 1'b1; in_data = 1'b1; clear = 1'b1;
    tick(1);
    in_valid = 1'b0; in_data = 1'b0; clear = 1'b0;
    chk("clrv_frame_bits", 64'(frame_bits), 64'd0);
    chk("clrv_out_valid", 64'(out_valid), 64'd0);
    chk("clrv_crc_val", 64'(crc_val), 64'd0);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 6; i++) drive_bit(1'b1, 1'b0);
    #2 RSTn = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_crc_val", 64'(crc_val), 64'd0);
    chk("arst_frame_bits", 64'(frame_bits), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    tick(2);
    RSTn = 1'b1;
    tick(1);
    send(64'h40_0000_0000, 40, 1'b0);
    chk("arst_after_crc", 64'(crc_val), 64'h4A);
    tick(12);

    // CRC16-CCITT over "123456789"
    s9 = 72'h31_32_33_34_35_36_37_38_39;
    n_done16 = 0;
    for (int i = 71; i >= 0; i--) begin
      v16 = 1'b1; d16 = s9[i]; l16 = (i == 0);
      tick(1);
    end
    v16 = 1'b0; d16 = 1'b0; l16 = 1'b0;
    chk("c16_crc", 64'(crc16), 64'h29B1);
    chk("c16_frame_bits", 64'(fb16), 64'd72);
    tick(22);
    chk("c16_ndone", 64'(n_done16), 64'd1);
    chk("c16_crc_init", 64'(crc16), 64'hFFFF);

`ifdef CRC_CHECK_EN
    // Check mode: good and corrupted frames
    clr_mon();
    chk_mode = 1'b1;
    send({17'd0, 40'h40_0000_0000, 7'h4A}, 47, 1'b0);
    chk_mode = 1'b0;
    tick(6);
    chk("chk_good_err", 64'(crc_err), 64'd0);
    chk("chk_good_ndone", 64'(d_cyc.size()), 64'd1);
    analyse();
    chk("chk_no_crc_out", 64'(f_nc[0]), 64'd0);
    chk("chk_nd", 64'(f_nd[0]), 64'd47);
    clr_mon();
    chk_mode = 1'b1;
    send({17'd0, 40'h40_0000_0001, 7'h4A}, 47, 1'b0);
    chk_mode = 1'b0;
    tick(6);
    chk("chk_bad_err", 64'(crc_err), 64'd1);
    chk("chk_bad_ndone", 64'(d_cyc.size()), 64'd1);
`endif

    chk("no_stalls", 64'(stalls), 64'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
